alu_operand_stage: RTL and testbench

Upstream feeder for the ALU. Holds the 8-entry general register file and reads two operands over two cycles. Applies the shifter to the B operand and the source selects (zero-A, sign-extended imm5 for B). Presents Ain/Bin/ALUop to the ALU under a valid/ready handshake. Writeback from downstream (ALU result / C register) enters through a dedicated write port.

---
 rtl/alu_operand_stage_if.sv | 36 +++
 rtl/alu_operand_stage.sv | 145 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: request side, operand handshake to the ALU, and register writeback.
// slave = the operand stage itself, master = the block driving it.
interface alu_operand_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] rn;
  logic [REG_AW-1:0] rm;
  logic [1:0]        shift;
  logic              asel;
  logic              bsel;
  logic [4:0]        imm5;
  logic [1:0]        alu_op_in;
  logic [DATA_W-1:0] Ain;
  logic [DATA_W-1:0] Bin;
  logic [1:0]        ALUop;
  logic              op_valid;
  logic              op_ready;
  logic              wb_en;
  logic [REG_AW-1:0] wb_num;
  logic [DATA_W-1:0] wb_data;

  modport slave (
    input  req_valid, rn, rm, shift, asel, bsel, imm5, alu_op_in,
    input  op_ready, wb_en, wb_num, wb_data,
    output req_ready, Ain, Bin, ALUop, op_valid
  );

  modport master (
    output req_valid, rn, rm, shift, asel, bsel, imm5, alu_op_in,
    output op_ready, wb_en, wb_num, wb_data,
    input  req_ready, Ain, Bin, ALUop, op_valid
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: 8-entry register file, two-cycle operand read, B shifter,
// zero-A / sign-extended-immediate source selects, valid/ready hand-off to the ALU.
// Optional macro FORWARD_EN: a read colliding with a same-edge writeback
// returns wb_data instead of the old register value.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned REG_AW = 3
) (
  input logic                 clk,
  input logic                 reset,
  alu_operand_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [4:0]        imm5;
    logic [1:0]        op;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] ain_q, bin_q;
  logic [1:0]        aluop_q;
  logic              op_valid_q;
  logic              req_ready_q;

  // B-operand shifter: none / lsl1 / lsr1 / asr1
  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v,
                                                input logic [1:0] sh);
    logic [DATA_W-1:0] r;
    case (sh)
      2'b01:   r = {v[DATA_W-2:0], 1'b0};
      2'b10:   r = {1'b0, v[DATA_W-1:1]};
      2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Sign-extend the 5-bit immediate to the operand width
  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
    return {{(DATA_W-5){imm[4]}}, imm};
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = READ_A;
      READ_A:  state_nxt = READ_B;
      READ_B:  state_nxt = VALID;
      VALID:   if (bus.op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered request-ready: high exactly while the FSM sits in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_ready_q <= 1'b1;
    else       req_ready_q <= (state_nxt == IDLE);
  end

  // Register file write port, independent of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en) begin
      regs[bus.wb_num] <= bus.wb_data;
    end
  end

  // Register read ports, with optional write-through on a same-edge collision
  always_comb begin
    rd_a = regs[req_q.rn];
    rd_b = regs[req_q.rm];
`ifdef FORWARD_EN
    if (bus.wb_en && (bus.wb_num == req_q.rn)) rd_a = bus.wb_data;
    if (bus.wb_en && (bus.wb_num == req_q.rm)) rd_b = bus.wb_data;
`endif
  end

  // Request capture and operand/output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      ain_q      <= '0;
      bin_q      <= '0;
      aluop_q    <= 2'b00;
      op_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q.rn    <= bus.rn;
            req_q.rm    <= bus.rm;
            req_q.shift <= bus.shift;
            req_q.asel  <= bus.asel;
            req_q.bsel  <= bus.bsel;
            req_q.imm5  <= bus.imm5;
            req_q.op    <= bus.alu_op_in;
          end
        end
        READ_A: begin
          ain_q <= req_q.asel ? '0 : rd_a;
        end
        READ_B: begin
          bin_q      <= req_q.bsel ? sext5(req_q.imm5) : shift_b(rd_b, req_q.shift);
          aluop_q    <= req_q.op;
          op_valid_q <= 1'b1;
        end
        VALID: begin
          if (bus.op_ready) op_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.ALUop     = aluop_q;
  assign bus.op_valid  = op_valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes expected operands,
// a negedge monitor pops and compares on each rising op_valid.
module tb_alu_operand_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned REG_AW = 3;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic prev_valid;

  alu_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_operand_stage #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    exp_t e;
    e.a = a; e.b = b; e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: req_ready stuck at %b after 20 cycles", bus.req_ready);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] data);
    bus.wb_en = 1'b1; bus.wb_num = idx; bus.wb_data = data;
    tick();
    bus.wb_en = 1'b0;
  endtask

  // Issues one request; returns just after the accepting edge
  task automatic do_req(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                        input logic asel, input logic bsel, input logic [4:0] imm,
                        input logic [1:0] op);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.rn = rn; bus.rm = rm; bus.shift = sh;
    bus.asel = asel; bus.bsel = bsel; bus.imm5 = imm; bus.alu_op_in = op;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Monitor: compare each newly presented operand set against the scoreboard
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.op_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: op_valid with Ain=0x%04h Bin=0x%04h, nothing expected",
                   bus.Ain, bus.Bin);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_Ain", bus.Ain, e.a);
          check("mon_Bin", bus.Bin, e.b);
          check("mon_ALUop", 16'(bus.ALUop), 16'(e.op));
        end
      end
      prev_valid = bus.op_valid;
    end
  end

  initial begin
    logic [15:0] coll_b, coll_a;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.rn = '0; bus.rm = '0; bus.shift = '0;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.imm5 = '0; bus.alu_op_in = '0;
    bus.op_ready = 1'b1; bus.wb_en = 1'b0; bus.wb_num = '0; bus.wb_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_req_ready", 16'(bus.req_ready), 16'h1);
    check("rst_op_valid", 16'(bus.op_valid), 16'h0);
    check("rst_Ain", bus.Ain, 16'h0000);
    check("rst_Bin", bus.Bin, 16'h0000);
    check("rst_ALUop", 16'(bus.ALUop), 16'h0);

    // Basic request from reset registers, with latency and req_ready timing
    push_exp(16'h0000, 16'h0000, 2'b10);
    do_req(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10);
    check("lat_ready_n0", 16'(bus.req_ready), 16'h0);
    check("lat_valid_n0", 16'(bus.op_valid), 16'h0);
    tick();
    check("lat_ready_n1", 16'(bus.req_ready), 16'h0);
    check("lat_valid_n1", 16'(bus.op_valid), 16'h0);
    tick();
    check("lat_valid_n2", 16'(bus.op_valid), 16'h1);
    check("lat_ready_n2", 16'(bus.req_ready), 16'h0);
    tick();
    check("lat_valid_n3", 16'(bus.op_valid), 16'h0);
    check("lat_ready_n3", 16'(bus.req_ready), 16'h1);

    // Plain register operands
    wr(3'd2, 16'h7FFF);
    wr(3'd3, 16'h0001);
    push_exp(16'h7FFF, 16'h0001, 2'b00);
    do_req(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00);

    // Shifter codes on R5 = 0x8003
    wr(3'd5, 16'h8003);
    push_exp(16'h0000, 16'h8003, 2'b00);
    do_req(3'd0, 3'd5, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00);
    push_exp(16'h0000, 16'h0006, 2'b01);
    do_req(3'd0, 3'd5, 2'b01, 1'b0, 1'b0, 5'd0, 2'b01);
    push_exp(16'h0000, 16'h4001, 2'b10);
    do_req(3'd0, 3'd5, 2'b10, 1'b0, 1'b0, 5'd0, 2'b10);
    push_exp(16'h0000, 16'hC001, 2'b11);
    do_req(3'd0, 3'd5, 2'b11, 1'b0, 1'b0, 5'd0, 2'b11);

    // Immediate and zero-A selects (shift ignored when bsel=1)
    push_exp(16'h0000, 16'hFFF0, 2'b01);
    do_req(3'd2, 3'd5, 2'b00, 1'b1, 1'b1, 5'b10000, 2'b01);
    push_exp(16'h0001, 16'h000F, 2'b10);
    do_req(3'd3, 3'd5, 2'b01, 1'b0, 1'b1, 5'b01111, 2'b10);

    // Back-pressure: hold in VALID while rewriting source registers
    wait_idle();
    bus.op_ready = 1'b0;
    push_exp(16'h7FFF, 16'h0001, 2'b11);
    do_req(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b11);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.wb_en   = 1'b1;
      bus.wb_num  = (i % 2 == 1) ? 3'd3 : 3'd2;
      bus.wb_data = (i % 2 == 1) ? 16'h5555 : 16'hAAAA;
      tick();
      check("hold_Ain", bus.Ain, 16'h7FFF);
      check("hold_Bin", bus.Bin, 16'h0001);
      check("hold_valid", 16'(bus.op_valid), 16'h1);
    end
    bus.wb_en = 1'b0;
    bus.op_ready = 1'b1;
    tick();
    check("release_valid", 16'(bus.op_valid), 16'h0);
    check("release_ready", 16'(bus.req_ready), 16'h1);
    check("release_Ain_kept", bus.Ain, 16'h7FFF);

    // Writes made during VALID are visible afterwards
    push_exp(16'hAAAA, 16'h5555, 2'b00);
    do_req(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00);

    // Collision on the B read edge
    wr(3'd4, 16'h1111);
`ifdef FORWARD_EN
    coll_b = 16'h2222;
    coll_a = 16'h3333;
`else
    coll_b = 16'h1111;
    coll_a = 16'h2222;
`endif
    push_exp(16'h0000, coll_b, 2'b01);
    do_req(3'd0, 3'd4, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01);
    tick();
    bus.wb_en = 1'b1; bus.wb_num = 3'd4; bus.wb_data = 16'h2222;
    tick();
    bus.wb_en = 1'b0;

    // Collision on the A read edge (R4 now 0x2222)
    push_exp(coll_a, 16'h0000, 2'b10);
    do_req(3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10);
    bus.wb_en = 1'b1; bus.wb_num = 3'd4; bus.wb_data = 16'h3333;
    tick();
    bus.wb_en = 1'b0;

    // Reset while in READ_B: operation discarded, everything cleared
    do_req(3'd5, 3'd4, 2'b00, 1'b0, 1'b0, 5'd0, 2'b11);
    tick();
    check("preRst_Ain", bus.Ain, 16'h8003);
    reset = 1'b1;
    #1;
    check("rstB_op_valid", 16'(bus.op_valid), 16'h0);
    check("rstB_Ain", bus.Ain, 16'h0000);
    check("rstB_Bin", bus.Bin, 16'h0000);
    check("rstB_ALUop", 16'(bus.ALUop), 16'h0);
    tick();
    reset = 1'b0;
    tick();
    check("rstB_req_ready", 16'(bus.req_ready), 16'h1);
    push_exp(16'h0000, 16'h0000, 2'b01);
    do_req(3'd5, 3'd4, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01);
    push_exp(16'h0000, 16'h0000, 2'b10);
    do_req(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10);
    wait_idle();
    tick();
    tick();
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
